// File: rtl/stream_sum_exerciser_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_sum_exerciser_if
// Description : Transmit and receive stream bundle between the running-sum
//               exerciser (master) and the running-sum kernel (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_sum_exerciser_if #(
   parameter int DATA_W = 128
);
   logic              tx_valid;
   logic              tx_rdy;
   logic [DATA_W-1:0] tx_data;
   logic              rx_valid;
   logic              rx_rdy;
   logic [DATA_W-1:0] rx_data;

   // Exerciser side: sources the tx stream, sinks the rx stream
   modport master (
      output tx_valid,
      output tx_data,
      input  tx_rdy,
      input  rx_valid,
      input  rx_data,
      output rx_rdy
   );

   // Kernel side: sinks the tx stream, sources the rx stream
   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_rdy,
      output rx_valid,
      output rx_data,
      input  rx_rdy
   );
endinterface
`default_nettype wire

// File: rtl/stream_sum_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : stream_sum_exerciser
// Description : Self-checking host-side endpoint for the running-sum kernel.
//               Sends SEED+k words, checks every response against a local
//               running sum, throttles rx_rdy with a rotating 8-bit pattern
//               and reports pass / error count / first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_sum_exerciser #(
   parameter int          DATA_W  = 128,
   parameter int          COUNT_W = 16,
   parameter logic [31:0] SEED    = 32'h0000_0001,
   parameter int          TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_W-1:0]     num_words,
   input  logic [7:0]             rdy_pattern,
   stream_sum_exerciser_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [COUNT_W-1:0]     err_count,
   output logic [COUNT_W-1:0]     first_err_idx
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [COUNT_W-1:0] r_num_words;
   logic [7:0]         r_rdy_pattern;
   logic [COUNT_W-1:0] r_tx_cnt;
   logic [COUNT_W-1:0] r_rx_cnt;
   logic [31:0]        r_exp_sum;
   logic [COUNT_W-1:0] r_err_count;
   logic [COUNT_W-1:0] r_first_err_idx;
   logic               r_timeout;
   logic [2:0]         r_phase;
   logic [TO_W-1:0]    r_idle_cnt;

   logic               w_busy;
   logic               w_tx_valid;
   logic               w_rx_rdy;
   logic               w_tx_hs;
   logic               w_rx_hs;
   logic               w_tx_last;
   logic               w_rx_last;
   logic               w_start_ok;
   logic               w_to_expire;
   logic               w_mismatch;

   logic [31:0]        w_tx_low;
   logic [31:0]        w_exp_low;
   logic [DATA_W-1:0]  w_tx_word;
   logic [DATA_W-1:0]  w_exp_word;

   // Low 32 bits of the current tx word and of the next expected response
   assign w_tx_low  = SEED + 32'(r_tx_cnt);
   assign w_exp_low = r_exp_sum + SEED + 32'(r_rx_cnt);

   // Upper tx bits are all ones so a kernel that fails to ignore them shows
   // up as a mismatch; expected responses are zero-extended.
   generate
      if (DATA_W > 32) begin : g_wide
         assign w_tx_word  = {{(DATA_W-32){1'b1}}, w_tx_low};
         assign w_exp_word = {{(DATA_W-32){1'b0}}, w_exp_low};
      end else begin : g_narrow
         assign w_tx_word  = w_tx_low;
         assign w_exp_word = w_exp_low;
      end
   endgenerate

   assign w_mismatch = (bus.rx_data != w_exp_word);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake decode and next-state selection; final rx beat wins over the
   // RUN->DRAIN move when both land in the same cycle
   always_comb begin
      w_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
      w_tx_valid  = (r_state == S_RUN) && (r_tx_cnt < r_num_words);
      w_rx_rdy    = w_busy && r_rdy_pattern[r_phase];
      w_tx_hs     = w_tx_valid && bus.tx_rdy;
      w_rx_hs     = w_rx_rdy && bus.rx_valid;
      w_tx_last   = w_tx_hs && (r_tx_cnt == (r_num_words - COUNT_W'(1)));
      w_rx_last   = w_rx_hs && (r_rx_cnt == (r_num_words - COUNT_W'(1)));
      w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
      w_to_expire = (r_state == S_DRAIN) && !w_rx_hs &&
                    (r_idle_cnt == TO_W'(TIMEOUT - 1));
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               w_state_nxt = (num_words == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_rx_last) begin
               w_state_nxt = S_DONE;
            end else if (w_tx_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_rx_last || w_to_expire) begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Run configuration, counters, running-sum checker and timeout watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_words     <= '0;
         r_rdy_pattern   <= '0;
         r_tx_cnt        <= '0;
         r_rx_cnt        <= '0;
         r_exp_sum       <= '0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
         r_timeout       <= 1'b0;
         r_phase         <= '0;
         r_idle_cnt      <= '0;
      end else if (w_start_ok) begin
         r_num_words     <= num_words;
         r_rdy_pattern   <= rdy_pattern;
         r_tx_cnt        <= '0;
         r_rx_cnt        <= '0;
         r_exp_sum       <= '0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
         r_timeout       <= 1'b0;
         r_phase         <= '0;
         r_idle_cnt      <= '0;
      end else begin
         if (w_tx_hs) begin
            r_tx_cnt <= r_tx_cnt + COUNT_W'(1);
         end
         if (w_rx_hs) begin
            r_exp_sum <= w_exp_low;
            r_rx_cnt  <= r_rx_cnt + COUNT_W'(1);
            if (w_mismatch) begin
               if (r_err_count != '1) begin
                  r_err_count <= r_err_count + COUNT_W'(1);
               end
               if (r_err_count == '0) begin
                  r_first_err_idx <= r_rx_cnt;
               end
            end
         end
         if (w_busy) begin
            r_phase <= r_phase + 3'd1;
         end
         // Counts only consecutive silent DRAIN cycles
         if ((r_state == S_DRAIN) && !w_rx_hs) begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
         end else begin
            r_idle_cnt <= '0;
         end
         if (w_to_expire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign bus.tx_valid  = w_tx_valid;
   assign bus.tx_data   = w_tx_valid ? w_tx_word : '0;
   assign bus.rx_rdy    = w_rx_rdy;
   assign busy          = w_busy;
   assign done          = (r_state == S_DONE);
   assign pass          = (r_state == S_DONE) && (r_err_count == '0) && !r_timeout;
   assign timeout       = r_timeout;
   assign err_count     = r_err_count;
   assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: doc/stream_sum_exerciser.md
Name: stream_sum_exerciser

Overview:
Self-checking stream endpoint for the running-sum stream kernel. It sits on the host side of both streams. It drives the kernel's input stream with a deterministic word sequence and consumes the kernel's output stream. Each response is compared against a locally computed running sum, and the block reports pass/fail, error count and first failing index. Receive backpressure is programmable so that stall paths in the kernel are exercised.

Parameters:
DATA_W, 128, width of tx_data and rx_data (must be >= 32)
COUNT_W, 16, width of word counters and the error counter
SEED, 32'h0000_0001, low-32-bit value of word 0
TIMEOUT, 1024, max consecutive cycles without an rx handshake in DRAIN before aborting (>= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
num_words  in  COUNT_W  words to send, sampled on accepted start
rdy_pattern  in  8  rx_rdy throttle pattern, sampled on accepted start
tx_valid  out  1  transmit word valid
tx_rdy  in  1  kernel accepts word
tx_data  out  DATA_W  transmit word
rx_valid  in  1  kernel response valid
rx_rdy  out  1  exerciser accepts response
rx_data  in  DATA_W  kernel response
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
pass  out  1  done & err_count==0 & !timeout
timeout  out  1  run aborted by TIMEOUT
err_count  out  COUNT_W  mismatching responses, saturating
first_err_idx  out  COUNT_W  index of first mismatch; valid only when err_count!=0

Behaviour:
- Reset (clk, rst synchronous active-high): state IDLE.
  - All outputs 0: tx_valid, rx_rdy, busy, done, pass, timeout, err_count, first_err_idx, tx_data.
  - Internal counters cleared.
  - Reset mid-run aborts immediately. tx_valid is 0 from the next edge, even if a word was pending.
- States:
  - IDLE: waits for start.
  - RUN: sending and receiving.
  - DRAIN: all words sent; collecting responses.
  - DONE: results held.
- Transitions:
  - IDLE/DONE + start: latch num_words and rdy_pattern; clear tx_cnt, rx_cnt, exp_sum, err_count, first_err_idx, timeout, phase. Go to RUN, or straight to DONE if num_words==0 (pass=1 one cycle later).
  - RUN: when the tx handshake of word num_words-1 completes, go to DRAIN.
  - RUN/DRAIN: when the rx handshake of response num_words-1 completes, go to DONE. This takes priority over the DRAIN move on the same cycle.
  - DRAIN: TIMEOUT consecutive cycles with no rx handshake -> DONE with timeout=1.
  - start while busy is ignored.
- TX word k: tx_data[31:0] = SEED + k (mod 2^32), tx_data[DATA_W-1:32] = all ones. The upper bits check that the kernel ignores them.
  - tx_valid=1 in RUN while tx_cnt < num_words.
  - tx_data is stable while tx_valid & !tx_rdy.
  - Handshake = tx_valid & tx_rdy; on handshake, tx_cnt++ and the next word is presented the following cycle. This sustains back-to-back throughput of 1 word/cycle.
  - tx_valid is never dropped before the handshake.
- RX throttle: rx_rdy = (RUN|DRAIN) & rdy_pattern[phase]. phase is a 3-bit counter incrementing every cycle in RUN/DRAIN. rdy_pattern = 8'hFF means no backpressure.
  - rx_rdy=0 in IDLE/DONE. Responses offered then are neither consumed nor checked.
- RX check on handshake j (rx_valid & rx_rdy):
  - expected = zero-extend(exp_sum + SEED + j, mod 2^32) to DATA_W.
  - Compare all DATA_W bits.
  - exp_sum <= exp_sum + SEED + j; rx_cnt++.
  - On mismatch: err_count++ (saturates at all ones); the first mismatch loads first_err_idx=j.
- RX may run ahead of or behind TX arbitrarily. The checker never requires rx_cnt <= tx_cnt.
- Simultaneous tx and rx handshakes in one cycle are both processed.
- DONE holds all result outputs until start or rst.

Test Plan:
- SEED=1, num_words=4, rdy_pattern=8'hFF, correct kernel -> tx low words 1,2,3,4; responses 1,3,6,10 accepted; done with pass=1 and err_count=0.
- SEED=1, num_words=16, rdy_pattern=8'b0101_0101, kernel tx_rdy toggling -> no tx word dropped or duplicated; final response 136; pass=1.
- SEED=32'hFFFF_FFFF, num_words=3 -> tx low words FFFFFFFF,0,1; expected FFFFFFFF,FFFFFFFF,0; pass=1 (wrap-around).
- Bench corrupts response index 2 (XOR 1) with num_words=5 -> err_count=1, first_err_idx=2, pass=0; run still completes all 5.
- Kernel never asserts rx_valid, num_words=2, TIMEOUT=1024 -> after both tx handshakes, DONE after 1024 idle cycles with timeout=1, pass=0. Separately, num_words=0 -> done and pass=1 with no tx_valid.
- rst asserted mid-RUN after 3 of 8 words -> next cycle tx_valid=0, busy=0, err_count=0; a following start with num_words=2 runs cleanly with pass=1.
